// File: rtl/switch_conditioner_pkg.sv
// Package for the switch conditioner.
// Purpose: types, sizes and small helper functions shared by the switch
// conditioner top level and its per-bit debounce sub-module.
// Ports: none (package).
package switch_conditioner_pkg;

`include "switch_defs.vh"

    // Switches per player.
    localparam int unsigned SWITCH_WIDTH = `SWITCH_WIDTH;

    // Default debounce length in clk cycles.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = `DEBOUNCE_CYCLES_DEFAULT;

    // Two players share one conditioner.
    localparam int unsigned NUM_PLAYERS = 2;

    // Total number of debounced bits.
    localparam int unsigned NUM_BITS = SWITCH_WIDTH * NUM_PLAYERS;

    // One player's switch vector.
    typedef logic [SWITCH_WIDTH-1:0] switch_vec_t;

    // Width of a counter that must be able to hold the value 'cycles'.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

    // Bits that are set now but were clear before (0->1 transitions).
    function automatic switch_vec_t rise_mask(input switch_vec_t now_v,
                                              input switch_vec_t old_v);
        return now_v & ~old_v;
    endfunction

endpackage

// File: rtl/switch_debounce_bit.sv
// Single-bit switch debouncer.
// Purpose: bring one asynchronous, bouncy switch into the clk domain and
// only change the debounced value after the synchronized input has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk   - system clock
//   reset - asynchronous, active-low reset
//   raw   - raw switch input, asynchronous to clk
//   deb   - debounced switch value (registered)
module switch_debounce_bit
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic deb
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);

    // The change is committed on the cycle the count would reach
    // DEBOUNCE_CYCLES, so the register itself never holds more than
    // DEBOUNCE_CYCLES-1 and can never wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             deb_r;
    logic [CNT_W-1:0] cnt_r;
    logic             deb_next_s;
    logic [CNT_W-1:0] cnt_next_s;

    // Next debounce state: clear on agreement, count on disagreement,
    // commit and clear when the count completes.
    always_comb begin
        deb_next_s = deb_r;
        cnt_next_s = cnt_r;
        if (sync2_r == deb_r) begin
            // A bounce back to the current value restarts the count.
            cnt_next_s = {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            deb_next_s = sync2_r;
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous raw input.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // Debounce counter and debounced value registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            deb_r <= 1'b0;
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            deb_r <= deb_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    assign deb = deb_r;

endmodule

// File: rtl/switch_defs.vh
// Shared switch-matrix definitions.
// Used by the switch conditioner and by the top-level display block so that
// both agree on the per-player switch count and the default debounce time.
`ifndef SWITCH_DEFS_VH
`define SWITCH_DEFS_VH

// Number of switches per player.
`define SWITCH_WIDTH 8

// Default number of consecutive stable cycles before a debounced bit changes.
`define DEBOUNCE_CYCLES_DEFAULT 16

`endif

// File: rtl/switch_conditioner.sv
// Two-player switch conditioner.
// Purpose: synchronize and debounce 2 x SWITCH_WIDTH switches, then latch
// them once per video frame so the displayed switch grid never changes
// mid-frame, and flag newly pressed switches with a one-cycle pulse.
// Ports:
//   clk         - system clock (only clock)
//   reset       - asynchronous, active-low reset
//   vsync       - vertical sync, active-high, clk domain
//   raw_p1/p2   - raw player switches, asynchronous, bouncy
//   switches_p1/p2 - debounced switches, updated on each frame tick
//   press_p1/p2 - one-cycle per-bit pulse on a latched 0->1 transition
//   frame_tick  - one-cycle pulse per vsync rising edge; it is high in the
//                 same cycle that the newly latched switches and press
//                 pulses first appear
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    vsync,
    input  logic [SWITCH_WIDTH-1:0] raw_p1,
    input  logic [SWITCH_WIDTH-1:0] raw_p2,
    output logic [SWITCH_WIDTH-1:0] switches_p1,
    output logic [SWITCH_WIDTH-1:0] switches_p2,
    output logic [SWITCH_WIDTH-1:0] press_p1,
    output logic [SWITCH_WIDTH-1:0] press_p2,
    output logic                    frame_tick
);

    logic [NUM_BITS-1:0]     raw_all_s;
    logic [NUM_BITS-1:0]     deb_all_s;
    switch_vec_t             deb_p1_s;
    switch_vec_t             deb_p2_s;
    logic                    tick_s;
    logic                    vsync_prev_r;
    logic                    frame_tick_r;
    switch_vec_t             switches_p1_r;
    switch_vec_t             switches_p2_r;
    switch_vec_t             press_p1_r;
    switch_vec_t             press_p2_r;

    // Flatten both players into one vector so one generate loop covers all bits.
    always_comb begin
        raw_all_s = {raw_p2, raw_p1};
    end

    // One independent synchronizer + debouncer per switch bit.
    for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
        switch_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_all_s[gi]),
            .deb   (deb_all_s[gi])
        );
    end

    // Split debounced bits per player and detect the vsync rising edge.
    always_comb begin
        deb_p1_s = deb_all_s[SWITCH_WIDTH-1:0];
        deb_p2_s = deb_all_s[NUM_BITS-1:SWITCH_WIDTH];
        tick_s   = vsync & ~vsync_prev_r;
    end

    // Previous-vsync register; resets high so a vsync already high when
    // reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_prev_r <= 1'b1;
            frame_tick_r <= 1'b0;
        end else begin
            vsync_prev_r <= vsync;
            frame_tick_r <= tick_s;
        end
    end

    // Frame latch: load debounced switches once per frame. deb_* is sampled
    // before the debouncers update on this same edge, so a change landing on
    // the tick edge is picked up at the following frame. Press pulses use
    // the previous latched value and are cleared on every other cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            switches_p1_r <= {SWITCH_WIDTH{1'b0}};
            switches_p2_r <= {SWITCH_WIDTH{1'b0}};
            press_p1_r    <= {SWITCH_WIDTH{1'b0}};
            press_p2_r    <= {SWITCH_WIDTH{1'b0}};
        end else begin
            if (tick_s) begin
                switches_p1_r <= deb_p1_s;
                switches_p2_r <= deb_p2_s;
                press_p1_r    <= rise_mask(deb_p1_s, switches_p1_r);
                press_p2_r    <= rise_mask(deb_p2_s, switches_p2_r);
            end else begin
                switches_p1_r <= switches_p1_r;
                switches_p2_r <= switches_p2_r;
                press_p1_r    <= {SWITCH_WIDTH{1'b0}};
                press_p2_r    <= {SWITCH_WIDTH{1'b0}};
            end
        end
    end

    assign switches_p1 = switches_p1_r;
    assign switches_p2 = switches_p2_r;
    assign press_p1    = press_p1_r;
    assign press_p2    = press_p2_r;
    assign frame_tick  = frame_tick_r;

endmodule

// File: doc/switch_conditioner.md
SWITCH_CONDITIONER -- requirements
Module: switch_conditioner

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, 16, consecutive stable cycles before a debounced bit changes (legal range 1..65535).
REQ-002 Port: clk  input  1  system clock; the only clock.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: vsync  input  1  vertical sync from the video sync generator, same clock domain, active-high.
REQ-005 Port: raw_p1  input  8  player 1 switches, asynchronous to clk, bouncy.
REQ-006 Port: raw_p2  input  8  player 2 switches, asynchronous to clk, bouncy.
REQ-007 Port: switches_p1  output  8  debounced player 1 switches, updated once per frame.
REQ-008 Port: switches_p2  output  8  debounced player 2 switches, updated once per frame.
REQ-009 Port: press_p1  output  8  per-bit one-cycle pulse on a frame-latched 0->1 transition of switches_p1.
REQ-010 Port: press_p2  output  8  per-bit one-cycle pulse on a frame-latched 0->1 transition of switches_p2.
REQ-011 Port: frame_tick  output  1  one-cycle pulse on each vsync rising edge.

Function
REQ-012 Each raw bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 Each bit SHALL have its own debounce state (deb) and counter of width clog2(DEBOUNCE_CYCLES+1).
REQ-014 Synced bit equal to deb: the counter SHALL clear to 0.
REQ-015 Synced bit differing from deb: the counter SHALL increment.
REQ-016 On the cycle the counter reaches DEBOUNCE_CYCLES, deb SHALL take the synced value and the counter SHALL clear.
REQ-017 Any bounce back to deb before the count completes SHALL restart the count from 0.
REQ-018 The counter SHALL never wrap.
REQ-019 frame_tick SHALL be high for exactly the one cycle where vsync=1 and the registered previous vsync=0.
REQ-020 On a frame_tick cycle, switches_pX SHALL load the current deb vector.
REQ-021 On a frame_tick cycle, press_pX SHALL load deb & ~switches_pX, using the old switches_pX value.
REQ-022 press_pX SHALL be 0 on every cycle that is not a frame_tick cycle.
REQ-023 switches_pX SHALL hold its value between frame_ticks, so the displayed grid never changes mid-frame.
REQ-024 If deb updates on the same edge as a frame_tick latch, the latch SHALL use the pre-update deb value; the new value is taken at the next frame_tick.
REQ-025 Latency from a stable raw change to a switches_pX change SHALL be 2 sync cycles + DEBOUNCE_CYCLES cycles, then wait for the next frame_tick, plus 1 register stage.
REQ-026 A 1->0 release SHALL update switches_pX and SHALL generate no press pulse.
REQ-027 vsync held high for multiple cycles SHALL produce a single frame_tick.

Reset
REQ-028 Reset asserted (low) SHALL asynchronously clear synchronizers, deb, counters, switches_pX, press_pX and frame_tick to 0.
REQ-029 Reset asserted SHALL asynchronously set the previous-vsync register to 1, so no frame_tick fires on the first cycle if vsync is high at release.
REQ-030 Reset asserted mid-debounce SHALL discard the partial count.

Structure
REQ-031 Shared header switch_defs.vh SHALL define SWITCH_WIDTH=8 and the default DEBOUNCE_CYCLES; the top-level display block and this block SHALL both use it.
REQ-032 One sub-module switch_debounce_bit (synchronizer, counter, deb flop) SHALL be instantiated 16 times via generate.
REQ-033 Frame latch and edge logic SHALL live in switch_conditioner.

Verification (DEBOUNCE_CYCLES=4)
REQ-034 Scenario: raw_p1=8'h01 held steady, then a vsync pulse -> switches_p1=8'h01 and press_p1=8'h01 for exactly one cycle after the tick; press_p1=0 at the next tick.
REQ-035 Scenario: raw_p2[3] toggles every 2 cycles for 40 cycles, then settles at 0 -> switches_p2 stays 8'h00 across all ticks.
REQ-036 Scenario: raw_p1 goes 8'hFF->8'h00 (release) -> switches_p1=8'h00 at the next tick, press_p1 never asserts.
REQ-037 Scenario: vsync high for 10 cycles -> exactly one frame_tick; raw change completing mid-frame -> switches unchanged until the next tick.
REQ-038 Scenario: reset pulled low mid-count with vsync high, then released -> all outputs 0, no frame_tick until vsync falls and rises again.
REQ-039 Scenario: deb update coincident with frame_tick -> the old value is latched, the new value appears one frame later.
